dmem_rmw_ctrl: RTL and testbench
================================

// Module: dmem_rmw_ctrl
// PURPOSE
//  Memory-side responder for CPU data accesses. Serves LB/LH/LW/LBU/LHU/SB/SH/SW
//  requests against a word-only synchronous data memory (no byte enables).
//  Loads: read word, extract and extend lane. SB/SH: read-modify-write (read, merge, write back).
//  Sits between the MEM stage and the data memory; valid/ready on both request and response.
// PARAMETERS
//  MEM_RD_LAT  1   cycles from the mem_re cycle to the cycle mem_rdata is valid (legal 1..4)
//  AW          32  byte-address width of req_addr
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  rst          in   1      asynchronous, active-high reset
//  req_valid    in   1      request present
//  req_ready    out  1      request accepted on the edge where req_valid&&req_ready
//  req_addr     in   AW     byte address
//  req_access   in   4      0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW; 8-15 illegal
//  req_wdata    in   32     store data, low byte/half used for SB/SH
//  resp_valid   out  1      response present; held until resp_ready
//  resp_ready   in   1      consumer takes response
//  resp_rdata   out  32     load result (0 for stores and errors)
//  resp_err     out  1      misaligned address or illegal access code
//  mem_addr     out  AW-2   word address (req_addr[AW-1:2])
//  mem_re       out  1      read strobe, one cycle
//  mem_we       out  1      write strobe, one cycle, full word
//  mem_wdata    out  32     word to write
//  mem_rdata    in   32     read word
// BEHAVIOUR
//  Reset: state IDLE, counter 0, all outputs 0 while rst high. req_ready=1 only in IDLE with rst low.
//  Request fields latched on accept; inputs ignored otherwise.
//  Error check at accept: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, code>=8 -> err.
//  FSM:
//   IDLE: accept -> err ? RESP(err=1) : SW ? WR : RD
//   RD:   mem_re=1 for one cycle -> WAIT, counter=MEM_RD_LAT
//   WAIT: decrement; mem_rdata valid on cycle counter==1, captured at that edge
//         load -> RESP (rdata extracted); SB/SH -> WR (merged word registered)
//   WR:   mem_we=1 one cycle, mem_wdata = merged word (SW: req_wdata) -> RESP
//   RESP: resp_valid=1; on resp_ready -> IDLE. rdata/err stable while waiting.
//  Latency, accept edge to first resp_valid cycle: error 1; SW 2; load MEM_RD_LAT+2;
//   SB/SH MEM_RD_LAT+3. Throughput: one request in flight; req_ready=0 outside IDLE.
//  Lane rules, byte k = addr[1:0] = word[8k+7:8k]; half h = addr[1] = word[16h+15:16h].
//   LB/LH sign-extend bit 7/15 of lane; LBU/LHU zero-extend; LW whole word.
//   SB replaces byte k with wdata[7:0]; SH replaces half h with wdata[15:0]; other bytes
//   keep the value read.
//  mem_addr driven from the latched address in RD and WR; 0 otherwise.
//  Error responses: no mem_re, no mem_we, resp_rdata=0.
//  Reset mid-operation: return to IDLE at once; a pending WR is dropped (no mem_we).
//  A mem_rdata change outside the capture cycle has no effect.
// TESTING (MEM_RD_LAT=1, word 0x100 = 0x8899AABB)
//  LB 0x101 -> resp_rdata 0xFFFFFFAA, err 0, valid 3 cycles after accept, no mem_we.
//  LHU 0x102 -> 0x00008899. LH 0x102 -> 0xFFFF8899. LW 0x100 -> 0x8899AABB.
//  SB 0x103 wdata 0x11 -> one mem_re, then mem_we with mem_wdata 0x1199AABB, mem_addr 0x40.
//  SH 0x101 / LW 0x102 / code 9 -> resp_err=1 next cycle, rdata 0, mem_re=mem_we=0 throughout.
//  resp_ready low 3 cycles -> resp_valid, resp_rdata held; req_ready 0; new req not taken.
//  rst pulse during WAIT of SB -> mem_we never asserted, outputs 0, req_ready=1 after release.

Source files
------------

// File: rtl/dmem_rmw_ctrl.sv
// dmem_rmw_ctrl: memory-side responder for CPU data accesses against a
// word-only synchronous data memory. Loads read a word and extract/extend one
// lane. Sub-word stores (SB/SH) read the word, merge the new lane and write
// the whole word back. Full-word stores (SW) write directly. One request is in
// flight at a time. Valid/ready handshakes are used on both the request side
// and the response side.
module dmem_rmw_ctrl #(
  parameter int MEM_RD_LAT = 1,   // mem_re cycle to mem_rdata-valid cycle, 1..4
  parameter int AW         = 32   // byte-address width
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [3:0]    req_access,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-3:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  // Access codes as carried on req_access.
  localparam logic [3:0] ACC_LB  = 4'd0;
  localparam logic [3:0] ACC_LH  = 4'd1;
  localparam logic [3:0] ACC_LW  = 4'd2;
  localparam logic [3:0] ACC_LBU = 4'd3;
  localparam logic [3:0] ACC_LHU = 4'd4;
  localparam logic [3:0] ACC_SB  = 4'd5;
  localparam logic [3:0] ACC_SH  = 4'd6;
  localparam logic [3:0] ACC_SW  = 4'd7;

  localparam logic [2:0] LAT = 3'(MEM_RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_RESP
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] addr_q;
  logic [3:0]    acc_q;
  logic [31:0]   word_q;     // store data at accept; merged word after capture
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [2:0]    cnt_q;
  logic          accept;
  logic          capture;
  logic          mem_active;

  // Misaligned halfword/word accesses and undefined codes are rejected at accept.
  function automatic logic access_err(input logic [3:0] acc, input logic [1:0] a);
    logic e;
    case (acc)
      ACC_LB, ACC_LBU, ACC_SB: e = 1'b0;
      ACC_LH, ACC_LHU, ACC_SH: e = a[0];
      ACC_LW, ACC_SW:          e = (a != 2'b00);
      default:                 e = 1'b1;
    endcase
    return e;
  endfunction

  // Select the addressed lane of the read word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [3:0] acc, input logic [1:0] a,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[8*a +: 8];
    h = w[16*a[1] +: 16];
    case (acc)
      ACC_LB:  r = {{24{b[7]}}, b};
      ACC_LBU: r = {24'h0, b};
      ACC_LH:  r = {{16{h[15]}}, h};
      ACC_LHU: r = {16'h0, h};
      ACC_LW:  r = w;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half of the read word with the store data.
  function automatic logic [31:0] store_merge(input logic [3:0] acc, input logic [1:0] a,
                                              input logic [31:0] w, input logic [31:0] d);
    logic [31:0] m;
    m = w;
    if (acc == ACC_SB) m[8*a +: 8] = d[7:0];
    else if (acc == ACC_SH) m[16*a[1] +: 16] = d[15:0];
    return m;
  endfunction

  assign accept     = req_valid && req_ready;
  assign req_ready  = (state == S_IDLE) && !rst;
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign resp_err   = resp_valid && err_q;
  assign mem_active = (state == S_RD) || (state == S_WR);
  assign mem_addr   = mem_active ? addr_q[AW-1:2] : '0;
  assign mem_wdata  = mem_we ? word_q : 32'h0;

  // State register; reset aborts any operation, including a pending write.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and memory strobes.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (access_err(req_access, req_addr[1:0])) state_next = S_RESP;
          else if (req_access == ACC_SW)             state_next = S_WR;
          else                                       state_next = S_RD;
        end
      end
      S_RD: begin
        mem_re     = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 3'd1) begin
          capture    = 1'b1;
          state_next = ((acc_q == ACC_SB) || (acc_q == ACC_SH)) ? S_WR : S_RESP;
        end
      end
      S_WR: begin
        mem_we     = 1'b1;
        state_next = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Request latch, read-latency counter and capture of the read word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      acc_q   <= 4'h0;
      word_q  <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        acc_q   <= req_access;
        word_q  <= req_wdata;
        rdata_q <= 32'h0;
        err_q   <= access_err(req_access, req_addr[1:0]);
      end
      if (state == S_RD)        cnt_q <= LAT;
      else if (state == S_WAIT) cnt_q <= cnt_q - 3'd1;
      if (capture) begin
        if ((acc_q == ACC_SB) || (acc_q == ACC_SH))
          word_q <= store_merge(acc_q, addr_q[1:0], mem_rdata, word_q);
        else
          rdata_q <= load_extract(acc_q, addr_q[1:0], mem_rdata);
      end
    end
  end

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Directed bench for dmem_rmw_ctrl with MEM_RD_LAT=1 and a small word memory
// model that returns data only in the cycle after mem_re.
module tb_dmem_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [3:0]  req_access = 4'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [29:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];
  int          re_cnt = 0;
  int          we_cnt = 0;
  logic [29:0] last_we_addr = '0;
  logic [31:0] last_we_data = '0;

  dmem_rmw_ctrl #(.MEM_RD_LAT(1), .AW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_access (req_access),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: data valid only in the cycle after mem_re, junk otherwise.
  always @(posedge clk) begin
    if (mem_re) begin
      re_cnt++;
      mem_rdata <= mem[mem_addr[5:0]];
    end else begin
      mem_rdata <= 32'h5A5A_5A5A;
    end
    if (mem_we) begin
      we_cnt++;
      mem[mem_addr[5:0]] = mem_wdata;
      last_we_addr = mem_addr;
      last_we_data = mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request with resp_ready high and check the response and memory traffic.
  task automatic run(input string tag, input logic [3:0] acc, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rdata, input logic exp_err,
                     input int exp_lat, input int exp_re, input int exp_we);
    int re0, we0, lat;
    @(negedge clk);
    re0 = re_cnt;
    we0 = we_cnt;
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_access = acc;
    req_addr   = addr;
    req_wdata  = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, resp_rdata, exp_rdata);
    check({tag, " err"}, 32'(resp_err), 32'(exp_err));
    @(negedge clk);
    check({tag, " mem_re count"}, 32'(re_cnt - re0), 32'(exp_re));
    check({tag, " mem_we count"}, 32'(we_cnt - we0), 32'(exp_we));
  endtask

  initial begin
    int re0, we0, n;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h8899_AABB;   // word address 0x40 (byte 0x100)

    // Reset state
    repeat (2) @(negedge clk);
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst mem_re", 32'(mem_re), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    rst = 1'b0;

    // Loads from word 0x100 = 0x8899AABB
    run("LB 0x101",  4'd0, 32'h101, 32'h0, 32'hFFFF_FFAA, 1'b0, 3, 1, 0);
    run("LHU 0x102", 4'd4, 32'h102, 32'h0, 32'h0000_8899, 1'b0, 3, 1, 0);
    run("LH 0x102",  4'd1, 32'h102, 32'h0, 32'hFFFF_8899, 1'b0, 3, 1, 0);
    run("LW 0x100",  4'd2, 32'h100, 32'h0, 32'h8899_AABB, 1'b0, 3, 1, 0);
    run("LBU 0x100", 4'd3, 32'h100, 32'h0, 32'h0000_00BB, 1'b0, 3, 1, 0);
    run("LH 0x100",  4'd1, 32'h100, 32'h0, 32'hFFFF_AABB, 1'b0, 3, 1, 0);

    // Sub-word stores: read-modify-write
    run("SB 0x103", 4'd5, 32'h103, 32'hFFFF_FF11, 32'h0, 1'b0, 4, 1, 1);
    check("SB mem_wdata", last_we_data, 32'h1199_AABB);
    check("SB mem_addr", 32'(last_we_addr), 32'h40);
    run("LW after SB", 4'd2, 32'h100, 32'h0, 32'h1199_AABB, 1'b0, 3, 1, 0);
    run("SH 0x102", 4'd6, 32'h102, 32'hCAFE_1234, 32'h0, 1'b0, 4, 1, 1);
    check("SH mem_wdata", last_we_data, 32'h1234_AABB);

    // Full-word store writes directly
    run("SW 0x104", 4'd7, 32'h104, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0, 1);
    check("SW mem_wdata", last_we_data, 32'hDEAD_BEEF);
    check("SW mem_addr", 32'(last_we_addr), 32'h41);
    run("LB 0x107",  4'd0, 32'h107, 32'h0, 32'hFFFF_FFDE, 1'b0, 3, 1, 0);
    run("LBU 0x105", 4'd3, 32'h105, 32'h0, 32'h0000_00BE, 1'b0, 3, 1, 0);
    run("LHU 0x106", 4'd4, 32'h106, 32'h0, 32'h0000_DEAD, 1'b0, 3, 1, 0);

    // Error responses
    run("SH 0x101 err",  4'd6, 32'h101, 32'h1234, 32'h0, 1'b1, 1, 0, 0);
    run("LW 0x102 err",  4'd2, 32'h102, 32'h0,    32'h0, 1'b1, 1, 0, 0);
    run("code 9 err",    4'd9, 32'h100, 32'h0,    32'h0, 1'b1, 1, 0, 0);
    run("LHU 0x103 err", 4'd4, 32'h103, 32'h0,    32'h0, 1'b1, 1, 0, 0);
    run("SW 0x101 err",  4'd7, 32'h101, 32'h0,    32'h0, 1'b1, 1, 0, 0);

    // Backpressure: response held, new request not taken
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_access = 4'd2; req_addr = 32'h100;
    @(negedge clk);
    req_access = 4'd5; req_addr = 32'h101; req_wdata = 32'h77;   // must be ignored
    n = 1;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    re0 = re_cnt;
    we0 = we_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold resp_valid", 32'(resp_valid), 32'd1);
      check("hold rdata", resp_rdata, 32'h1234_AABB);
      check("hold req_ready", 32'(req_ready), 32'd0);
    end
    check("hold no mem_re", 32'(re_cnt - re0), 32'd0);
    check("hold no mem_we", 32'(we_cnt - we0), 32'd0);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    check("release resp_valid", 32'(resp_valid), 32'd0);
    check("release req_ready", 32'(req_ready), 32'd1);

    // Reset during WAIT of an SB drops the write
    we0 = we_cnt;
    req_valid = 1'b1; req_access = 4'd5; req_addr = 32'h100; req_wdata = 32'h55;
    @(negedge clk);          // accepted at previous posedge; now in RD
    req_valid = 1'b0;
    @(negedge clk);          // WAIT
    rst = 1'b1;
    #1;
    check("midrst mem_we", 32'(mem_we), 32'd0);
    check("midrst mem_addr", 32'(mem_addr), 32'd0);
    check("midrst resp_valid", 32'(resp_valid), 32'd0);
    check("midrst req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst no write", 32'(we_cnt - we0), 32'd0);
    check("midrst req_ready after", 32'(req_ready), 32'd1);
    run("LW after rst", 4'd2, 32'h100, 32'h0, 32'h1234_AABB, 1'b0, 3, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
